// File: rtl/multi_uart_tx_if.sv
// Shared write port of the multi-channel UART transmitter: one byte per
// cycle, steered to a channel by wr_ch.
interface multi_uart_tx_if #(
  parameter int NCH = 2
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          wr_en;
  logic [CW-1:0] wr_ch;
  logic [7:0]    wr_data;

  modport master (output wr_en, wr_ch, wr_data);
  modport slave  (input  wr_en, wr_ch, wr_data);
endinterface

// File: rtl/multi_uart_tx.sv
// Multi-channel UART transmitter: NCH independent lanes, each a TX FIFO
// feeding a frame FSM, sharing one baud divisor and frame format.
module multi_uart_tx_ch #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_par,
  input  logic             cfg_stop2,
  input  logic             wr,
  input  logic [7:0]       wr_data,
  input  logic             ovf_clr,
  output logic             txd,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             ovf
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [AW:0]      wp, rp, wp_n, rp_n;
  logic [DIV_W-1:0] cnt, div_q;
  logic [7:0]       dat, head;
  logic [2:0]       bitn;
  logic             par_en, par_bit, stop2_q, stop_n;
  logic             bit_end, pop, wr_ok;

  assign head    = mem[rp[AW-1:0]];
  assign bit_end = (cnt == '0);
  // Pop from IDLE, or at the very end of the last stop bit so frames chain gaplessly.
  assign pop     = !empty && (state == IDLE ||
                   (state == STOP && bit_end && (!stop2_q || stop_n)));
  assign wr_ok   = wr && !full;
  assign wp_n    = wp + {{AW{1'b0}}, wr_ok};
  assign rp_n    = rp + {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wp[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      wp    <= wp_n;
      rp    <= rp_n;
      empty <= (wp_n == rp_n);
      full  <= (wp_n[AW] != rp_n[AW]) && (wp_n[AW-1:0] == rp_n[AW-1:0]);
      // Overflow judged on the pre-pop full flag; set beats clear.
      if (wr && full)   ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      cnt     <= '0;
      div_q   <= '0;
      dat     <= '0;
      bitn    <= '0;
      par_en  <= 1'b0;
      par_bit <= 1'b0;
      stop2_q <= 1'b0;
      stop_n  <= 1'b0;
    end else if (pop) begin
      // Frame format is latched here and held for the whole frame.
      state   <= START;
      txd     <= 1'b0;
      busy    <= 1'b1;
      cnt     <= baud_div;
      div_q   <= baud_div;
      dat     <= head;
      par_en  <= ^cfg_par;
      par_bit <= (^head) ^ cfg_par[1];
      stop2_q <= cfg_stop2;
      stop_n  <= 1'b0;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt <= cnt - DIV_W'(1);
      end else begin
        cnt <= div_q;
        case (state)
          START: begin
            state <= DATA;
            bitn  <= '0;
            txd   <= dat[0];
          end
          DATA: begin
            if (bitn == 3'd7) begin
              state <= par_en ? PARITY : STOP;
              txd   <= par_en ? par_bit : 1'b1;
            end else begin
              bitn <= bitn + 3'd1;
              txd  <= dat[bitn + 3'd1];
            end
          end
          PARITY: begin
            state <= STOP;
            txd   <= 1'b1;
          end
          STOP: begin
            if (stop2_q && !stop_n) begin
              stop_n <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              txd   <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

module multi_uart_tx #(
  parameter int NCH   = 2,
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [1:0]       cfg_par,
  input  logic             cfg_stop2,
  multi_uart_tx_if.slave   bus,
  input  logic [NCH-1:0]   ie,
  input  logic [NCH-1:0]   ovf_clr,
  output logic [NCH-1:0]   txd,
  output logic [NCH-1:0]   full,
  output logic [NCH-1:0]   empty,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   ovf,
  output logic             irq
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  // Out-of-range wr_ch matches no lane, so such writes vanish silently.
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr;
    assign wr = bus.wr_en && (bus.wr_ch == CW'(i));

    multi_uart_tx_ch #(.DEPTH(DEPTH), .DIV_W(DIV_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .baud_div  (baud_div),
      .cfg_par   (cfg_par),
      .cfg_stop2 (cfg_stop2),
      .wr        (wr),
      .wr_data   (bus.wr_data),
      .ovf_clr   (ovf_clr[i]),
      .txd       (txd[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .busy      (busy[i]),
      .ovf       (ovf[i])
    );
  end

  assign irq = |(ie & empty & ~busy);
endmodule
